// File: rtl/gs_bridge_pkg.sv
// Shared types for the General Sound memory bridge: FSM states,
// line buffer record, line geometry and a byte-select helper.
package gs_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DRAIN
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [17:0] tag;
        logic [63:0] data;
    } line_t;

    localparam int LINE_BYTES = 8;
    localparam int TAG_W      = 18;

    function automatic logic [7:0] get_byte(input logic [63:0] d,
                                            input logic [2:0]  s);
        return d[{s, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gs_line_buf.sv
// One 64-bit line buffer: tag/valid/data storage, hit compare,
// byte read mux and single-byte write merge on hit.
// Ports: clk, reset (sync, active-high); look_tag/look_sel select the
// line/byte to compare and read; hit, rd_byte results; fill_en/_valid/
// _tag/_data load a whole line; wr_en/wr_byte merge one byte on hit.
module gs_line_buf
    import gs_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [TAG_W-1:0]  look_tag,
    input  logic [2:0]        look_sel,
    output logic              hit,
    output logic [7:0]        rd_byte,
    input  logic              fill_en,
    input  logic              fill_valid,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [63:0]       fill_data,
    input  logic              wr_en,
    input  logic [7:0]        wr_byte
);

    line_t line_q, line_d;

    assign hit     = line_q.valid && (line_q.tag == look_tag);
    assign rd_byte = get_byte(line_q.data, look_sel);

    always_comb begin
        line_d = line_q;
        if (fill_en) begin
            line_d.valid = fill_valid;
            line_d.tag   = fill_tag;
            line_d.data  = fill_data;
        end else if (wr_en && hit) begin
            line_d.data[{look_sel, 3'b000} +: 8] = wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/gs_mem_bridge.sv
// GS byte memory port (21-bit addr, rd/wr levels, ready) to 64-bit Avalon
// DDRAM with a one-line read buffer; writes go through to DDRAM.
// Ports: clk_sys, reset (sync, active-high); addr/din/dout/rd/wr/ready on
// the GS side; DDRAM_* Avalon master (BUSY = waitrequest).
// Macro GS_BRIDGE_PREFETCH_EN adds a next-line buffer filled by a 2-beat burst.
module gs_mem_bridge
    import gs_bridge_pkg::*;
#(
    parameter logic [28:0] BASE_WORD = 29'h0600000,
    parameter int          ADDR_W    = 21
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              rd,
    input  logic              wr,
    output logic              ready,
    input  logic              DDRAM_BUSY,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic [28:0]       DDRAM_ADDR,
    input  logic [63:0]       DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic              DDRAM_RD,
    output logic [63:0]       DDRAM_DIN,
    output logic [7:0]        DDRAM_BE,
    output logic              DDRAM_WE
);

`ifdef GS_BRIDGE_PREFETCH_EN
    localparam logic [7:0] BURST = 8'd2;
`else
    localparam logic [7:0] BURST = 8'd1;
`endif

    state_t              state_q, state_d;
    logic                served_q, served_d;
    logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
    logic [7:0]          dout_q, dout_d;
    logic [7:0]          be_q, be_d;
    logic [63:0]         din_q, din_d;
    // Beats still owed by DDRAM; survives reset so late beats get drained.
    logic [1:0]          owed_q, owed_d;

    logic                req;
    logic                served_eff;
    logic                complete;
    logic                rd_acc;
    logic [ADDR_W-1:0]   look_addr;
    logic [TAG_W-1:0]    look_tag;
    logic [TAG_W-1:0]    acc_tag;
    logic [2:0]          look_sel;
    logic [2:0]          acc_sel;
    logic [7:0]          beat_byte;
    logic                a_hit;
    logic [7:0]          a_byte;
    logic                a_fill;
    logic                wr_merge;
    logic                any_hit;
    logic [7:0]          hit_byte;

    assign req = rd | wr;
    // served only counts for the address it was earned on.
    assign served_eff = served_q & req & (addr == acc_addr_q);
    assign ready      = served_eff | ~req;

    // In IDLE compare the live address; otherwise the accepted one.
    assign look_addr = (state_q == IDLE) ? addr : acc_addr_q;
    assign look_tag  = look_addr[ADDR_W-1:3];
    assign look_sel  = look_addr[2:0];
    assign acc_tag   = acc_addr_q[ADDR_W-1:3];
    assign acc_sel   = acc_addr_q[2:0];
    assign beat_byte = get_byte(DDRAM_DOUT, acc_sel);

    gs_line_buf u_buf_a (
        .clk        (clk_sys),
        .reset      (reset),
        .look_tag   (look_tag),
        .look_sel   (look_sel),
        .hit        (a_hit),
        .rd_byte    (a_byte),
        .fill_en    (a_fill),
        .fill_valid (1'b1),
        .fill_tag   (acc_tag),
        .fill_data  (DDRAM_DOUT),
        .wr_en      (wr_merge),
        .wr_byte    (din_q[7:0])
    );

`ifdef GS_BRIDGE_PREFETCH_EN
    logic       b_hit;
    logic [7:0] b_byte;
    logic       b_fill;
    logic       beat0;

    // Line 2^18-1 has no successor: B is left invalid.
    gs_line_buf u_buf_b (
        .clk        (clk_sys),
        .reset      (reset),
        .look_tag   (look_tag),
        .look_sel   (look_sel),
        .hit        (b_hit),
        .rd_byte    (b_byte),
        .fill_en    (b_fill),
        .fill_valid (~&acc_tag),
        .fill_tag   (acc_tag + 18'd1),
        .fill_data  (DDRAM_DOUT),
        .wr_en      (wr_merge),
        .wr_byte    (din_q[7:0])
    );

    assign any_hit  = a_hit | b_hit;
    assign hit_byte = a_hit ? a_byte : b_byte;
    assign beat0    = (owed_q == 2'd2);
`else
    assign any_hit  = a_hit;
    assign hit_byte = a_byte;
`endif

    always_comb begin
        owed_d = owed_q;
        if (rd_acc) begin
            owed_d = owed_d + BURST[1:0];
        end
        if (DDRAM_DOUT_READY && (owed_q != 2'd0)) begin
            owed_d = owed_d - 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_addr_d = acc_addr_q;
        be_d       = be_q;
        din_d      = din_q;
        dout_d     = dout_q;
        complete   = 1'b0;
        rd_acc     = 1'b0;
        a_fill     = 1'b0;
        wr_merge   = 1'b0;
`ifdef GS_BRIDGE_PREFETCH_EN
        b_fill     = 1'b0;
`endif
        DDRAM_RD   = 1'b0;
        DDRAM_WE   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !served_eff) begin
                    acc_addr_d = addr;
                    be_d       = 8'd1 << addr[2:0];
                    din_d      = {LINE_BYTES{din}};
                    if (wr) begin
                        state_d = WR_REQ;
                    end else if (any_hit) begin
                        dout_d   = hit_byte;
                        complete = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                DDRAM_RD = 1'b1;
                if (!DDRAM_BUSY) begin
                    rd_acc  = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (DDRAM_DOUT_READY) begin
`ifdef GS_BRIDGE_PREFETCH_EN
                    if (beat0) begin
                        a_fill   = 1'b1;
                        dout_d   = beat_byte;
                        complete = 1'b1;
                    end else begin
                        b_fill  = 1'b1;
                        state_d = IDLE;
                    end
`else
                    a_fill   = 1'b1;
                    dout_d   = beat_byte;
                    complete = 1'b1;
                    state_d  = IDLE;
`endif
                end
            end
            WR_REQ: begin
                DDRAM_WE = 1'b1;
                if (!DDRAM_BUSY) begin
                    wr_merge = 1'b1;
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (owed_d == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        served_d = complete | served_eff;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= (owed_d != 2'd0) ? DRAIN : IDLE;
            served_q   <= 1'b0;
            acc_addr_q <= '0;
            dout_q     <= 8'd0;
            be_q       <= 8'd0;
            din_q      <= 64'd0;
        end else begin
            state_q    <= state_d;
            served_q   <= served_d;
            acc_addr_q <= acc_addr_d;
            dout_q     <= dout_d;
            be_q       <= be_d;
            din_q      <= din_d;
        end
        owed_q <= owed_d;
    end

    assign dout           = dout_q;
    assign DDRAM_BURSTCNT = BURST;
    assign DDRAM_ADDR     = BASE_WORD + {11'd0, acc_tag};
    assign DDRAM_DIN      = din_q;
    assign DDRAM_BE       = be_q;

endmodule

// File: tb/tb_gs_mem_bridge.sv
// Directed bench for gs_mem_bridge with a DDRAM responder model,
// a byte memory model and an expected-dout scoreboard queue.
module tb_gs_mem_bridge;

    localparam logic [28:0] BASE = 29'h0600000;
`ifdef GS_BRIDGE_PREFETCH_EN
    localparam int  EXP_BURST = 2;
    localparam bit  PF        = 1'b1;
`else
    localparam int  EXP_BURST = 1;
    localparam bit  PF        = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd, wr, ready;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    gs_mem_bridge dut (
        .clk_sys          (clk),
        .reset            (reset),
        .addr             (addr),
        .din              (din),
        .dout             (dout),
        .rd               (rd),
        .wr               (wr),
        .ready            (ready),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_WE         (DDRAM_WE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [28:0] w;
        int          idx;
        int          due;
    } beat_t;

    logic [63:0] mem [logic [28:0]];
    beat_t       beats [$];
    logic [7:0]  exp_q [$];

    int          checks = 0;
    int          failures = 0;
    int          stall = 0;
    int          lat = 2;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          we_cycles = 0;
    int          beat_cyc = 0;
    logic [28:0] last_rd_addr = '0;
    int          last_burst = 0;
    logic [28:0] last_we_addr = '0;
    logic [7:0]  last_be = '0;
    logic [63:0] last_din = '0;

    function automatic logic [63:0] mem_rd(input logic [28:0] w);
        if (mem.exists(w)) return mem[w];
        return {3'd0, w, 3'd0, w} ^ 64'h0123456789ABCDEF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // DDRAM responder: decides BUSY and beats on each falling edge.
    initial begin
        logic [63:0] m;
        beat_t       b;
        DDRAM_BUSY       = 1'b0;
        DDRAM_DOUT_READY = 1'b0;
        DDRAM_DOUT       = '0;
        forever begin
            @(negedge clk);
            DDRAM_DOUT_READY = 1'b0;
            if (beats.size() > 0 && beats[0].due <= cyc) begin
                b = beats.pop_front();
                DDRAM_DOUT       = mem_rd(b.w);
                DDRAM_DOUT_READY = 1'b1;
                if (b.idx == 0) beat_cyc = cyc;
            end
            if (DDRAM_WE) we_cycles++;
            if ((DDRAM_RD || DDRAM_WE) && stall > 0) begin
                DDRAM_BUSY = 1'b1;
                stall--;
            end else begin
                DDRAM_BUSY = 1'b0;
                if (DDRAM_RD) begin
                    rd_cnt++;
                    last_rd_addr = DDRAM_ADDR;
                    last_burst   = int'(DDRAM_BURSTCNT);
                    for (int i = 0; i < int'(DDRAM_BURSTCNT); i++) begin
                        beats.push_back('{DDRAM_ADDR + 29'(i), i, cyc + lat + i});
                    end
                end
                if (DDRAM_WE) begin
                    wr_cnt++;
                    last_we_addr = DDRAM_ADDR;
                    last_be      = DDRAM_BE;
                    last_din     = DDRAM_DIN;
                    m = mem_rd(DDRAM_ADDR);
                    for (int i = 0; i < 8; i++) begin
                        if (DDRAM_BE[i]) m[i*8 +: 8] = DDRAM_DIN[i*8 +: 8];
                    end
                    mem[DDRAM_ADDR] = m;
                end
            end
        end
    end

    task automatic do_read(input logic [20:0] a, input bit miss);
        int          n0;
        int          low;
        logic [63:0] w;
        n0 = rd_cnt;
        w  = mem_rd(BASE + {11'd0, a[20:3]});
        exp_q.push_back(w[{a[2:0], 3'b000} +: 8]);
        tick;
        addr = a;
        rd   = 1'b1;
        wr   = 1'b0;
        #1;
        chk("rd_ready_low", ready, 1'b0);
        low = 0;
        tick;
        while (!ready && low < 100) begin
            low++;
            tick;
        end
        chk("rd_timeout", ready, 1'b1);
        chk("rd_dout", dout, exp_q.pop_front());
        chk("rd_issued", rd_cnt - n0, miss);
        if (miss) begin
            chk("rd_burst", last_burst, EXP_BURST);
            chk("rd_addr", last_rd_addr, BASE + {11'd0, a[20:3]});
            chk("rd_rise", cyc - beat_cyc, 1);
        end else begin
            chk("hit_low_cycles", low, 0);
        end
        rd = 1'b0;
    endtask

    task automatic do_write(input logic [20:0] a, input logic [7:0] d,
                            input int st, input bit both);
        int n0;
        int w0;
        int low;
        n0        = rd_cnt;
        w0        = wr_cnt;
        stall     = st;
        we_cycles = 0;
        tick;
        addr = a;
        din  = d;
        wr   = 1'b1;
        rd   = both;
        #1;
        chk("wr_ready_low", ready, 1'b0);
        low = 0;
        tick;
        while (!ready && low < 100) begin
            low++;
            tick;
        end
        chk("wr_timeout", ready, 1'b1);
        chk("wr_we_hold", we_cycles, st + 1);
        chk("wr_low_cycles", low, st + 1);
        chk("wr_be", last_be, 8'd1 << a[2:0]);
        chk("wr_din", last_din, {8{d}});
        chk("wr_addr", last_we_addr, BASE + {11'd0, a[20:3]});
        chk("wr_count", wr_cnt - w0, 1);
        chk("wr_no_read", rd_cnt - n0, 0);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        int n0;
        int k;
        reset = 1'b1;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        din   = '0;
        mem[BASE + 29'd2] = 64'h8877665544332211;
        repeat (3) tick;

        chk("rst_dout", dout, 8'h00);
        chk("rst_ready", ready, 1'b1);
        chk("rst_rd", DDRAM_RD, 1'b0);
        chk("rst_we", DDRAM_WE, 1'b0);
        chk("rst_burst", DDRAM_BURSTCNT, EXP_BURST);
        chk("rst_be", DDRAM_BE, 8'h00);
        chk("rst_din", DDRAM_DIN, 64'h0);
        chk("rst_addr", DDRAM_ADDR, BASE);
        reset = 1'b0;
        tick;

        do_read(21'h00010, 1'b1);
        do_read(21'h00013, 1'b0);
        do_write(21'h00015, 8'hA5, 3, 1'b0);
        do_read(21'h00015, 1'b0);
        do_write(21'h1FFFF8, 8'h5A, 2, 1'b1);

        // Reset one cycle after DDRAM takes a read; the late beat must vanish.
        mem[BASE + 29'h100] = 64'hFFFF_FFFF_FFFF_FFFF;
        lat = 4;
        n0  = rd_cnt;
        tick;
        addr = 21'h00800;
        rd   = 1'b1;
        k    = 0;
        while (rd_cnt == n0 && k < 100) begin
            k++;
            tick;
        end
        chk("rst_rd_accepted", rd_cnt - n0, 1);
        tick;
        reset = 1'b1;
        rd    = 1'b0;
        tick;
        reset = 1'b0;
        chk("rst_mid_dout", dout, 8'h00);
        chk("rst_mid_rd", DDRAM_RD, 1'b0);
        chk("rst_mid_ready", ready, 1'b1);
        k = 0;
        while (beats.size() != 0 && k < 100) begin
            k++;
            tick;
        end
        chk("drain_timeout", beats.size(), 0);
        repeat (2) tick;
        lat = 2;
        mem[BASE + 29'h100] = 64'h0807060504030201;
        do_read(21'h00803, 1'b1);

        do_read(21'h1FFFF8, 1'b1);
        do_read(21'h000000, 1'b1);
        do_read(21'h000008, !PF);
        repeat (4) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
